// File: rtl/uart_stim_tx_pkg.sv
// Shared definitions for the stimulus UART transmitter: FSM encoding and
// the baud divisor helper.
package uart_stim_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Rounded clocks-per-bit.
    function automatic int calc_div(input int f_clk, input int f_baud);
        return (f_clk + f_baud / 2) / f_baud;
    endfunction

endpackage

// File: rtl/uart_stim_tx_fifo.sv
// Single-clock byte FIFO with registered read data, level output and
// synchronous reset. Pointers carry one extra MSB to tell full from empty.
module uart_stim_tx_fifo #(
    parameter int dw = 8,
    parameter int aw = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [dw-1:0] i_wr_data,
    input  logic          i_wr_en,
    input  logic          i_rd_en,
    output logic [dw-1:0] o_rd_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [aw:0]   o_level
);

    logic [dw-1:0] r_mem [0:(1<<aw)-1];
    logic [aw:0]   r_wr_ptr;
    logic [aw:0]   r_rd_ptr;
    logic [dw-1:0] r_rd_data;
    logic          w_push;
    logic          w_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[aw] != r_rd_ptr[aw]) &&
                       (r_wr_ptr[aw-1:0] == r_rd_ptr[aw-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_rd_data;
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr[aw-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (aw+1)'(1);
            end
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr[aw-1:0]];
                r_rd_ptr  <= r_rd_ptr + (aw+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_stim_tx.sv
// 8N1/8N2 UART transmitter fed by a byte FIFO; drives a serial line that
// idles high. Back-to-back frames leave no idle gap.
module uart_stim_tx
    import uart_stim_tx_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 1152000,
    parameter int fifo_aw        = 4,
    parameter int stop_bits      = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic             o_uart_txd,
    output logic             o_busy,
    output logic             o_tx_done,
    output logic [fifo_aw:0] o_fifo_level,
    output logic [1:0]       o_dbg_state
);

    localparam int DIV = calc_div(clk_freq, uart_baud_rate);
    localparam int CW  = $clog2(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("uart_stim_tx: baud divisor must be at least 2");
    end
    if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
        $error("uart_stim_tx: stop_bits must be 1 or 2");
    end

    tx_state_t     r_state;
    tx_state_t     w_next_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    w_rd_data;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_bit_end;
    logic          w_frame_end;

    uart_stim_tx_fifo #(.dw(8), .aw(fifo_aw)) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_data (i_tx_data),
        .i_wr_en   (i_tx_valid),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (o_fifo_level)
    );

    assign w_bit_end   = (r_baud == CW'(DIV - 1));
    assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (r_bit == 3'(stop_bits - 1));
    // Popping at the last stop cycle lets the next start bit follow directly.
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_frame_end);
    assign o_tx_ready  = !w_full;
    assign o_busy      = (r_state != ST_IDLE) || (o_fifo_level != '0);
    assign o_dbg_state = r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '1;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end
            if (w_frame_end) begin
                r_bit <= '0;
            end else if (w_bit_end && r_state != ST_START) begin
                r_bit <= r_bit + 3'd1;
            end
            // Registered FIFO data is stable through START; latch it at its end.
            if (r_state == ST_START && w_bit_end) begin
                r_shift <= w_rd_data;
            end else if (r_state == ST_DATA && w_bit_end) begin
                r_shift <= {1'b1, r_shift[7:1]};
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (!w_empty) w_next_state = ST_START;
            ST_START: if (w_bit_end) w_next_state = ST_DATA;
            ST_DATA:  if (w_bit_end && r_bit == 3'd7) w_next_state = ST_STOP;
            ST_STOP:  if (w_frame_end) w_next_state = w_empty ? ST_IDLE : ST_START;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_uart_txd = 1'b1;
        o_tx_done  = 1'b0;
        unique case (r_state)
            ST_START: o_uart_txd = 1'b0;
            ST_DATA:  o_uart_txd = r_shift[0];
            ST_STOP:  o_tx_done  = w_frame_end;
            default:  ;
        endcase
    end

endmodule
